baud_tick_gen: RTL and testbench

Parametrised baud-rate timing generator for the UART transmit/receive engines. Decodes a 4-bit baud-rate select into a bit-time divisor computed from the system clock frequency, then runs the bit-time counter itself. Produces single-cycle full-bit, half-bit and oversample strobes. Sits between the switch/baud-select logic and the transmit and receive engines, so they consume strobes instead of implementing their own bit-time counters.

---
 rtl/baud_tick_gen_if.sv | 24 ++
 rtl/baud_tick_gen.sv | 129 ++++++++++++
 tb/tb_baud_tick_gen.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/baud_tick_gen_if.sv
// Control and strobe bundle between the baud-select logic, the tick generator
// and the UART transmit/receive engines.
interface baud_tick_gen_if #(
  parameter int CNT_W = 20
);
  logic [3:0]       baud;
  logic             enable;
  logic             restart;
  logic             bit_tick;
  logic             half_tick;
  logic             os_tick;
  logic [CNT_W-1:0] k_out;

  // The engine side drives rate/enable/restart and consumes strobes.
  modport master (
    output baud, enable, restart,
    input  bit_tick, half_tick, os_tick, k_out
  );

  modport slave (
    input  baud, enable, restart,
    output bit_tick, half_tick, os_tick, k_out
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Baud-rate timing generator: decodes a 4-bit rate select into a bit-time
// divisor and produces registered full-bit, mid-bit and oversample strobes.
module baud_tick_gen #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int CNT_W      = 20,
  parameter int OVERSAMPLE = 16
) (
  input logic            clk,
  input logic            reset,
  baud_tick_gen_if.slave bus
);

  localparam longint unsigned CLK_L = 64'(CLK_HZ);
  localparam longint unsigned OS_L  = 64'(OVERSAMPLE);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  function automatic longint unsigned rate_of(input int code);
    case (code)
      1:       return 64'd1200;
      2:       return 64'd2400;
      3:       return 64'd4800;
      4:       return 64'd9600;
      5:       return 64'd19200;
      6:       return 64'd38400;
      7:       return 64'd57600;
      8:       return 64'd115200;
      9:       return 64'd230400;
      10:      return 64'd460800;
      11:      return 64'd921600;
      default: return 64'd300;
    endcase
  endfunction

  function automatic longint unsigned k_of(input int code);
    longint unsigned r = rate_of(code);
    longint unsigned k = (CLK_L + r / 64'd2) / r;
    return (k < 64'd2) ? 64'd2 : k;
  endfunction

  function automatic longint unsigned os_of(input longint unsigned k);
    longint unsigned o = (k + OS_L / 64'd2) / OS_L;
    return (o < 64'd1) ? 64'd1 : o;
  endfunction

  if (OVERSAMPLE < 1 || OVERSAMPLE > 64) begin : g_bad_oversample
    $error("baud_tick_gen: OVERSAMPLE must lie in 1..64");
  end

  if (k_of(0) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
    $error("baud_tick_gen: CNT_W too narrow for the 300 baud divisor");
  end

  // Divisors are elaboration constants; the select only picks an entry.
  logic [CNT_W-1:0] k_lut  [16];
  logic [CNT_W-1:0] os_lut [16];

  for (genvar i = 0; i < 16; i++) begin : g_lut
    assign k_lut[i]  = CNT_W'(k_of(i));
    assign os_lut[i] = CNT_W'(os_of(k_of(i)));
  end

  logic [CNT_W-1:0] k_dec;
  logic [CNT_W-1:0] os_dec;

  assign k_dec  = k_lut[bus.baud];
  assign os_dec = os_lut[bus.baud];

  logic [CNT_W-1:0] bc;
  logic [CNT_W-1:0] oc;
  logic [CNT_W-1:0] k_act;
  logic [CNT_W-1:0] os_k;
  logic             bit_q;
  logic             half_q;
  logic             os_q;

  logic             terminal;
  logic             os_wrap;
  logic [CNT_W-1:0] half_pt;

  assign terminal = (bc == k_act - ONE);
  assign os_wrap  = (oc == os_k - ONE);
  assign half_pt  = (k_act >> 1) - ONE;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of bc/oc/k_act regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || bus.restart) begin
      bc     <= '0;
      oc     <= '0;
      bit_q  <= 1'b0;
      half_q <= 1'b0;
      os_q   <= 1'b0;
      k_act  <= k_dec;
      os_k   <= os_dec;
    end else if (bus.enable) begin
      half_q <= (bc == half_pt);
      if (terminal) begin
        // NOTE: the divisor only reloads at a bit boundary, so a rate change
        // never shortens or stretches the bit already in progress.
        bc    <= '0;
        oc    <= '0;
        bit_q <= 1'b1;
        os_q  <= 1'b1;
        k_act <= k_dec;
        os_k  <= os_dec;
      end else begin
        bc    <= bc + ONE;
        bit_q <= 1'b0;
        if (os_wrap) begin
          oc   <= '0;
          os_q <= 1'b1;
        end else begin
          oc   <= oc + ONE;
          os_q <= 1'b0;
        end
      end
    end else begin
      bit_q  <= 1'b0;
      half_q <= 1'b0;
      os_q   <= 1'b0;
    end
  end

  assign bus.bit_tick  = bit_q;
  assign bus.half_tick = half_q;
  assign bus.os_tick   = os_q;
  assign bus.k_out     = k_act;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: three instances (default, OVERSAMPLE=1,
// and a 1 MHz clock to reach the 300 baud divisor and the K=2 clamp quickly).
module tb_baud_tick_gen;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  baud_tick_gen_if #(.CNT_W(20)) b0 ();
  baud_tick_gen_if #(.CNT_W(20)) b1 ();
  baud_tick_gen_if #(.CNT_W(12)) b2 ();

  baud_tick_gen #(.CLK_HZ(100_000_000), .CNT_W(20), .OVERSAMPLE(16)) dut0 (
    .clk(clk), .reset(reset), .bus(b0)
  );
  baud_tick_gen #(.CLK_HZ(100_000_000), .CNT_W(20), .OVERSAMPLE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );
  baud_tick_gen #(.CLK_HZ(1_000_000), .CNT_W(12), .OVERSAMPLE(16)) dut2 (
    .clk(clk), .reset(reset), .bus(b2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Edge count since the last restart/reset edge of each instance.
  int cyc0 = 0, cyc1 = 0, cyc2 = 0;
  int bq0[$], hq0[$], oq0[$];
  int bq1[$], hq1[$], oq1[$];
  int bq2[$], hq2[$], oq2[$];
  int exp_q[$];

  always @(posedge clk) begin
    cyc0 <= (reset || b0.restart) ? 0 : cyc0 + 1;
    cyc1 <= (reset || b1.restart) ? 0 : cyc1 + 1;
    cyc2 <= (reset || b2.restart) ? 0 : cyc2 + 1;
  end

  always @(posedge clk) begin
    #1;
    if (b0.bit_tick)  bq0.push_back(cyc0);
    if (b0.half_tick) hq0.push_back(cyc0);
    if (b0.os_tick)   oq0.push_back(cyc0);
    if (b1.bit_tick)  bq1.push_back(cyc1);
    if (b1.half_tick) hq1.push_back(cyc1);
    if (b1.os_tick)   oq1.push_back(cyc1);
    if (b2.bit_tick)  bq2.push_back(cyc2);
    if (b2.half_tick) hq2.push_back(cyc2);
    if (b2.os_tick)   oq2.push_back(cyc2);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_q(input string tag, input int got[$], input int exp[$]);
    check({tag, ".count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp[i]));
  endtask

  // Oversample timeline for continuous enable: strides of osk inside each
  // bit, plus one strobe at every bit boundary.
  task automatic os_expect(input int k, input int osk, input int last, output int q[$]);
    q.delete();
    for (int base = 0; base < last; base += k) begin
      for (int t = base + osk; t < base + k && t <= last; t += osk) q.push_back(t);
      if (base + k <= last) q.push_back(base + k);
    end
  endtask

  function automatic int cur(input int w);
    case (w)
      0:       return cyc0;
      1:       return cyc1;
      default: return cyc2;
    endcase
  endfunction

  task automatic clear_q(input int w);
    case (w)
      0: begin bq0.delete(); hq0.delete(); oq0.delete(); end
      1: begin bq1.delete(); hq1.delete(); oq1.delete(); end
      default: begin bq2.delete(); hq2.delete(); oq2.delete(); end
    endcase
  endtask

  // Called at a falling edge; returns at the falling edge after the restart edge.
  task automatic restart(input int w);
    clear_q(w);
    case (w)
      0: b0.restart = 1'b1;
      1: b1.restart = 1'b1;
      default: b2.restart = 1'b1;
    endcase
    @(negedge clk);
    b0.restart = 1'b0;
    b1.restart = 1'b0;
    b2.restart = 1'b0;
  endtask

  task automatic run_to(input int w, input int n);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cur(w) != n && guard < 20000);
    if (cur(w) != n) check($sformatf("run_to%0d timeout", w), 64'(cur(w)), 64'(n));
  endtask

  initial begin
    reset = 1'b1;
    b0.baud = 4'b1000; b0.enable = 1'b0; b0.restart = 1'b0;
    b1.baud = 4'b1011; b1.enable = 1'b0; b1.restart = 1'b0;
    b2.baud = 4'b1111; b2.enable = 1'b0; b2.restart = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst bit_tick",  64'(b0.bit_tick),  64'd0);
    check("rst half_tick", 64'(b0.half_tick), 64'd0);
    check("rst os_tick",   64'(b0.os_tick),   64'd0);
    check("rst k_out0",    64'(b0.k_out),     64'd868);
    check("rst k_out1",    64'(b1.k_out),     64'd109);
    check("rst k_out2",    64'(b2.k_out),     64'd3333);
    reset = 1'b0;
    b0.enable = 1'b1; b1.enable = 1'b1; b2.enable = 1'b1;
    @(negedge clk);

    // 115200 baud: K=868, H=434, OS_K=54
    restart(0);
    check("k868", 64'(b0.k_out), 64'd868);
    run_to(0, 2700);
    exp_q = '{868, 1736, 2604};
    check_q("k868 bit", bq0, exp_q);
    exp_q = '{434, 1302, 2170};
    check_q("k868 half", hq0, exp_q);
    os_expect(868, 54, 2700, exp_q);
    check_q("k868 os", oq0, exp_q);

    // 921600 baud: K=109, H=54, OS_K=7, ten bits
    b0.baud = 4'b1011;
    restart(0);
    check("k109", 64'(b0.k_out), 64'd109);
    run_to(0, 1095);
    exp_q.delete();
    for (int i = 1; i <= 10; i++) exp_q.push_back(109 * i);
    check_q("k109 bit", bq0, exp_q);
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(54 + 109 * i);
    check_q("k109 half", hq0, exp_q);
    os_expect(109, 7, 1095, exp_q);
    check_q("k109 os", oq0, exp_q);

    // Reserved codes fall back to 300 baud
    b0.baud = 4'b1100;
    restart(0);
    check("code1100 k", 64'(b0.k_out), 64'd333333);
    b0.baud = 4'b1111;
    restart(0);
    check("code1111 k", 64'(b0.k_out), 64'd333333);

    // 1 MHz instance, code 1111: K=3333, H=1666
    restart(2);
    run_to(2, 3340);
    exp_q = '{3333};
    check_q("k3333 bit", bq2, exp_q);
    exp_q = '{1666};
    check_q("k3333 half", hq2, exp_q);

    // 1 MHz instance, 921600 baud: K clamps to 2, OS_K=1
    b2.baud = 4'b1011;
    restart(2);
    check("clamp k", 64'(b2.k_out), 64'd2);
    run_to(2, 8);
    exp_q = '{2, 4, 6, 8};
    check_q("clamp bit", bq2, exp_q);
    exp_q = '{1, 3, 5, 7};
    check_q("clamp half", hq2, exp_q);
    exp_q = '{1, 2, 3, 4, 5, 6, 7, 8};
    check_q("clamp os", oq2, exp_q);

    // Rate change mid-bit: 115200 -> 230400 at cycle 300
    b0.baud = 4'b1000;
    restart(0);
    run_to(0, 300);
    b0.baud = 4'b1001;
    run_to(0, 867);
    check("switch k before", 64'(b0.k_out), 64'd868);
    run_to(0, 868);
    check("switch k after", 64'(b0.k_out), 64'd434);
    run_to(0, 1310);
    exp_q = '{868, 1302};
    check_q("switch bit", bq0, exp_q);
    exp_q = '{434, 1085};
    check_q("switch half", hq0, exp_q);

    // Enable low for 100 cycles after the mid-bit point
    b0.baud = 4'b1000;
    restart(0);
    run_to(0, 500);
    b0.enable = 1'b0;
    run_to(0, 600);
    b0.enable = 1'b1;
    run_to(0, 1000);
    exp_q = '{968};
    check_q("gap bit", bq0, exp_q);
    exp_q = '{434};
    check_q("gap half", hq0, exp_q);
    exp_q.delete();
    for (int i = 1; i <= 9; i++)  exp_q.push_back(54 * i);
    for (int i = 10; i <= 16; i++) exp_q.push_back(54 * i + 100);
    exp_q.push_back(968);
    check_q("gap os", oq0, exp_q);

    // Restart on the terminal-count cycle suppresses that tick
    b0.baud = 4'b1011;
    restart(0);
    run_to(0, 108);
    restart(0);
    run_to(0, 120);
    exp_q = '{109};
    check_q("tc restart bit", bq0, exp_q);
    os_expect(109, 7, 120, exp_q);
    check_q("tc restart os", oq0, exp_q);

    // Reset on the cycle a half_tick would be set
    restart(0);
    run_to(0, 53);
    clear_q(0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid rst bit",  64'(b0.bit_tick),  64'd0);
    check("mid rst half", 64'(b0.half_tick), 64'd0);
    check("mid rst os",   64'(b0.os_tick),   64'd0);
    check("mid rst k",    64'(b0.k_out),     64'd109);
    run_to(0, 115);
    exp_q = '{109};
    check_q("mid rst bitq", bq0, exp_q);
    exp_q = '{54};
    check_q("mid rst halfq", hq0, exp_q);

    // OVERSAMPLE=1 at K=109: os strobes only at bit boundaries
    restart(1);
    run_to(1, 330);
    exp_q = '{109, 218, 327};
    check_q("os1 bit", bq1, exp_q);
    check_q("os1 os", oq1, exp_q);
    exp_q = '{54, 163, 272};
    check_q("os1 half", hq1, exp_q);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
